// File: rtl/viterbi_pkg.sv
// Shared types for the 4-state (K=3, rate-1/2) Viterbi decoder control path.
package viterbi_pkg;

    localparam int NUM_STATES = 4;

    typedef logic [1:0] state_idx_t;
    typedef logic [3:0] dec_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FILL,
        TSTART,
        TRACE
    } seq_state_t;

endpackage

// File: rtl/viterbi_surv_mem.sv
// Survivor decision store: one write port, one asynchronous full-row read port, no reset.
module viterbi_surv_mem
    import viterbi_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  dec_vec_t          wdata,
    input  logic [ADDR_W-1:0] raddr,
    output dec_vec_t          rdata
);

    dec_vec_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_frame_seq.sv
// Frame sequencer for the K=3 Viterbi decoder: fills survivor memory, then traces back.
// Build option VITERBI_SEQ_TERMINATED_EN: traceback always starts from state 0.
module viterbi_frame_seq
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] rx_pair,
    output logic [1:0] bmc_pair,
    output logic       metric_clr,
    output logic       acs_en,
    input  dec_vec_t   acs_dec,
    input  state_idx_t sm_best,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    seq_state_t        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    state_idx_t        tb_state;
    state_idx_t        tb_next;
    state_idx_t        tb_start;
    dec_vec_t          rd_row;

    assign acs_en   = in_valid & in_ready;
    assign bmc_pair = in_ready ? rx_pair : 2'b00;

    // Step back one trellis stage: predecessor = {s[0], decision bit of s}.
    assign tb_next = {tb_state[0], rd_row[tb_state]};

`ifdef VITERBI_SEQ_TERMINATED_EN
    assign tb_start = 2'b00;
`else
    assign tb_start = sm_best;
`endif

    viterbi_surv_mem #(
        .DEPTH (FRAME_LEN),
        .ADDR_W(ADDR_W)
    ) u_surv (
        .clk  (clk),
        .we   (acs_en),
        .waddr(wr_ptr),
        .wdata(acs_dec),
        .raddr(rd_ptr),
        .rdata(rd_row)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tb_state   <= 2'b00;
            in_ready   <= 1'b0;
            metric_clr <= 1'b0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state      <= INIT;
                    metric_clr <= 1'b1;
                end
                INIT: begin
                    state      <= FILL;
                    metric_clr <= 1'b0;
                    wr_ptr     <= '0;
                    in_ready   <= 1'b1;
                end
                FILL: begin
                    if (acs_en) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == LAST) begin
                            state    <= TSTART;
                            in_ready <= 1'b0;
                        end
                    end
                end
                TSTART: begin
                    state     <= TRACE;
                    tb_state  <= tb_start;
                    rd_ptr    <= LAST;
                    out_valid <= 1'b1;
                    out_bit   <= tb_start[1];
                    out_last  <= 1'b0;
                end
                TRACE: begin
                    if (out_ready) begin
                        tb_state <= tb_next;
                        rd_ptr   <= rd_ptr - 1'b1;
                        out_bit  <= tb_next[1];
                        out_last <= (rd_ptr == ADDR_W'(1));
                        if (out_last) begin
                            state      <= INIT;
                            metric_clr <= 1'b1;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_frame_seq.sv
// Randomized self-checking bench for viterbi_frame_seq with FRAME_LEN = 8.
module tb_viterbi_frame_seq;

    localparam int FL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] rx_pair = 2'b00;
    logic [1:0] bmc_pair;
    logic       metric_clr;
    logic       acs_en;
    logic [3:0] acs_dec = 4'h0;
    logic [1:0] sm_best = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic       out_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] frame_dec [FL];

    viterbi_frame_seq #(.FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rx_pair   (rx_pair),
        .bmc_pair  (bmc_pair),
        .metric_clr(metric_clr),
        .acs_en    (acs_en),
        .acs_dec   (acs_dec),
        .sm_best   (sm_best),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic int start_state(input int best);
`ifdef VITERBI_SEQ_TERMINATED_EN
        return 0;
`else
        return best;
`endif
    endfunction

    // Assert reset, check outputs held at zero, release and check the startup sequence.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; rx_pair = 2'b11; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({in_ready, metric_clr, acs_en, out_valid, out_bit, out_last, bmc_pair} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {in_ready, metric_clr, acs_en, out_valid, out_bit, out_last, bmc_pair});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (metric_clr !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cycle0 got clr=%b rdy=%b want 0 0", metric_clr, in_ready);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (metric_clr !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cycle1 got clr=%b rdy=%b want 1 0", metric_clr, in_ready);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (metric_clr !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_cycle2 got clr=%b rdy=%b want 0 1", metric_clr, in_ready);
        end
    endtask

    // gap_mode: 0 always valid, 1 every other cycle, 2 random.
    // out_mode: 0 always ready, 1 random, 2 three-cycle stall after the 2nd bit.
    // abort_after >= 0 returns once that many bits have been accepted.
    task automatic run_frame(input int gap_mode, input int out_mode, input int best,
                             input int abort_after);
        int exp_bits [FL];
        int s, hs, cyc, i, stall_left;
        bit stalled;
        s = start_state(best);
        for (int t = FL - 1; t >= 0; t--) begin
            exp_bits[FL - 1 - t] = s / 2;
            s = (s % 2) * 2 + ((int'(frame_dec[t]) >> s) & 1);
        end

        hs = 0; cyc = 0;
        while (hs < FL && cyc < 200) begin
            @(negedge clk);
            case (gap_mode)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            rx_pair = 2'($urandom);
            acs_dec = frame_dec[hs];
            sm_best = 2'(best);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1 || acs_en !== in_valid || bmc_pair !== rx_pair) begin
                n_err++;
                $display("FAIL fill_hs%0d got rdy=%b en=%b pair=%b want 1 %b %b",
                         hs, in_ready, acs_en, bmc_pair, in_valid, rx_pair);
            end
            if (in_valid) hs++;
            cyc++;
        end
        n_cmp++;
        if (hs != FL) begin
            n_err++;
            $display("FAIL fill_count got=%0d want=%0d", hs, FL);
        end
        @(negedge clk);
        in_valid = 1'b1; rx_pair = 2'b11;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || acs_en !== 1'b0 || bmc_pair !== 2'b00) begin
            n_err++;
            $display("FAIL tstart got rdy=%b ov=%b en=%b pair=%b want 0 0 0 00",
                     in_ready, out_valid, acs_en, bmc_pair);
        end

        i = 0; cyc = 0; stall_left = 0; stalled = 0;
        while (i < FL && cyc < 200) begin
            if (abort_after >= 0 && i == abort_after) return;
            @(negedge clk);
            rx_pair = 2'($urandom);
            case (out_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 9) < 7);
                default: begin
                    if (i == 2 && !stalled) begin stalled = 1; stall_left = 3; end
                    out_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_bit !== 1'(exp_bits[i]) || out_last !== (i == FL - 1)
                || in_ready !== 1'b0 || acs_en !== 1'b0) begin
                n_err++;
                $display("FAIL trace_bit%0d got ov=%b bit=%b last=%b rdy=%b want 1 %0d %b 0",
                         i, out_valid, out_bit, out_last, in_ready, exp_bits[i], i == FL - 1);
            end
            if (out_ready) i++;
            cyc++;
        end
        n_cmp++;
        if (i != FL) begin
            n_err++;
            $display("FAIL trace_count got=%0d want=%0d", i, FL);
        end
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || metric_clr !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL frame_end got ov=%b clr=%b rdy=%b want 0 1 0",
                     out_valid, metric_clr, in_ready);
        end
    endtask

    task automatic test_zero_frame();
        for (int k = 0; k < FL; k++) frame_dec[k] = 4'b0000;
        run_frame(0, 0, 0, -1);
    endtask

    task automatic test_ones_frame();
        for (int k = 0; k < FL; k++) frame_dec[k] = 4'b1111;
        run_frame(0, 0, 3, -1);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < FL; k++) frame_dec[k] = 4'($urandom);
        run_frame(0, 2, int'($urandom_range(0, 3)), -1);
    endtask

    task automatic test_input_gaps();
        for (int k = 0; k < FL; k++) frame_dec[k] = 4'($urandom);
        run_frame(1, 0, int'($urandom_range(0, 3)), -1);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < FL; k++) frame_dec[k] = 4'($urandom);
        run_frame(0, 0, 1, 3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, metric_clr, acs_en, out_valid, out_bit, out_last, bmc_pair} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid got=%b want=00000000",
                     {in_ready, metric_clr, acs_en, out_valid, out_bit, out_last, bmc_pair});
        end
        test_reset();
        for (int k = 0; k < FL; k++) frame_dec[k] = 4'($urandom);
        run_frame(0, 0, int'($urandom_range(0, 3)), -1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < FL; k++) frame_dec[k] = 4'($urandom);
            run_frame(2, 1, int'($urandom_range(0, 3)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_ones_frame();
        test_backpressure();
        test_input_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_seq.md
# viterbi_frame_seq

Frame sequencer for the 4-state (K=3, rate-1/2) Viterbi decoder. Accepts received symbol pairs over a valid/ready handshake and feeds them to the branch-metric/ACS datapath with one update enable per symbol. Stores the per-step ACS survivor decisions in an internal survivor memory and, once a frame is complete, runs traceback to emit decoded bits over a second valid/ready handshake. It owns all decoder control; the BMC and ACS blocks stay purely datapath.

## Interface
- FRAME_LEN, 16: trellis steps per frame, including tail steps; must be ≥ 2.
- ADDR_W, $clog2(FRAME_LEN): survivor memory address width.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  rx_pair is valid
- in_ready  output  1  sequencer accepts a symbol
- rx_pair  input  2  received symbol pair
- bmc_pair  output  2  rx_pair forwarded to the BMC bank; equals rx_pair when in_ready is high, 2'b00 otherwise
- metric_clr  output  1  one-cycle pulse: ACS loads metric 0 into state 0 and maximum metric into states 1-3
- acs_en  output  1  ACS registers new metrics this cycle
- acs_dec  input  4  survivor decision per state, valid when acs_en is high; bit s = predecessor LSB for state s
- sm_best  input  2  index of the minimum-metric state, taken from the registered metrics
- out_valid  output  1  out_bit is valid
- out_ready  input  1  consumer accepts out_bit
- out_bit  output  1  decoded bit, emitted last-step-first
- out_last  output  1  marks the final bit of the frame (trellis step 0)

## Operation
- State encoding: s = {u_t, u_t-1}. Next state = {u, s[1]}. Decoded bit at step t = s[1] of the state reached after step t. Predecessor of s = {s[0], acs_dec_t[s]}.
- FSM states are IDLE, INIT, FILL, TSTART and TRACE.
  - IDLE: entered on reset; moves to INIT unconditionally on the next cycle.
  - INIT: metric_clr = 1 for exactly one cycle; wr_ptr ← 0; moves to FILL.
  - FILL: in_ready = 1.
    - acs_en = in_valid & in_ready.
    - On each acs_en, surv[wr_ptr] ← acs_dec and wr_ptr increments.
    - On the handshake with wr_ptr = FRAME_LEN-1, move to TSTART.
  - TSTART: one cycle. tb_state ← start state (see Configuration); rd_ptr ← FRAME_LEN-1. Moves to TRACE.
  - TRACE: out_valid = 1; out_bit = tb_state[1]; out_last = (rd_ptr = 0).
    - On out_valid & out_ready: tb_state ← {tb_state[0], surv[rd_ptr][tb_state]} and rd_ptr decrements.
    - On the handshake with out_last = 1, move to INIT.
- Survivor memory: FRAME_LEN × 4 register array. It is not reset and is written only in FILL.
- The sequencer never overlaps frames. in_ready is low in INIT, TSTART and TRACE.

## Timing
- Reset values: in_ready, metric_clr, acs_en, out_valid, out_bit and out_last are 0; bmc_pair is 2'b00; wr_ptr, rd_ptr and tb_state are 0.
- After rst deasserts: IDLE for cycle 0, metric_clr in cycle 1, in_ready from cycle 2.
- in_ready, out_valid, out_bit and out_last are registered-state decodes with no combinational path from in_valid or out_ready.
- acs_en and bmc_pair are combinational from in_valid and rx_pair.
- Latency is measured from the last input handshake, at edge N, to the first out_valid:
  - TSTART is the cycle after edge N;
  - out_valid is high in the following cycle.
- Frame period with no stalls: 1 + FRAME_LEN + 1 + FRAME_LEN cycles.
- Backpressure: while out_ready = 0, out_valid, out_bit, out_last, tb_state and rd_ptr hold.
- Input gaps: in_valid low in FILL produces no write and no acs_en.
- Reset mid-operation, at any state: outputs go to reset values asynchronously and the frame is discarded. The sequence restarts at IDLE after release.

## Configuration
- VITERBI_SEQ_TERMINATED_EN
  - Defined: the trellis is zero-terminated. TSTART loads tb_state ← 2'b00 and sm_best is ignored.
  - Undefined: TSTART loads tb_state ← sm_best.

## Structure
- Shared package viterbi_pkg holds:
  - NUM_STATES = 4;
  - the state-index typedef (logic [1:0]);
  - the decision-vector typedef (logic [3:0]);
  - the FSM enum type (IDLE, INIT, FILL, TSTART, TRACE).
- One sub-module, viterbi_surv_mem: survivor register array with one write port and one asynchronous read port. The read port returns the full row; bit selection is done in the sequencer.

## Test plan
The bench drives acs_dec from a stub; FRAME_LEN = 8.
1. Reset → all outputs 0 during reset; metric_clr high in exactly cycle 1 after release; in_ready high from cycle 2.
2. 8 symbols, acs_dec = 4'b0000, start state 0 → 8 bits all 0; out_last only on the 8th; in_ready low throughout TRACE.
3. acs_dec = 4'b1111, start state 3 (sm_best = 3 when the macro is undefined) → 8 bits all 1.
4. out_ready held low for 3 cycles after the 2nd output bit → out_bit and out_valid stable while low; exactly 8 bits total; out_last on the 8th.
5. in_valid asserted every other cycle → acs_en pulses only on handshakes; exactly 8 writes; TSTART follows the 8th handshake.
6. rst asserted after 3 output bits → outputs 0 immediately; after release, metric_clr is pulsed and a fresh 8-symbol frame decodes correctly.
